// File: rtl/hazard_pkg.sv
// Shared constants for the pipeline hazard scoreboard: defaults, forward-select encodings, entry layout.
package hazard_pkg;
   localparam int DEPTH_DEF      = 3;
   localparam int LOAD_STAGE_DEF = 2;
   localparam int REG_AW_DEF     = 5;

   localparam int FWD_RF = 0;

   // Destination part of an entry, carried by every tracked stage.
   localparam int E_VALID    = 0;
   localparam int E_REGWRITE = 1;
   localparam int E_IS_LOAD  = 2;
   localparam int E_RD       = 3;

   // Source part, held by stage 0 only, stored directly above the destination part.
   localparam int S_RS1_USE = 0;
   localparam int S_RS2_USE = 1;
   localparam int S_RS1     = 2;

   function automatic int s_rs2(input int aw);
      return S_RS1 + aw;
   endfunction

   function automatic int dst_w(input int aw);
      return E_RD + aw;
   endfunction

   function automatic int src_w(input int aw);
      return S_RS1 + 2 * aw;
   endfunction

   function automatic int entry_w(input int aw);
      return dst_w(aw) + src_w(aw);
   endfunction
endpackage

// File: rtl/hazard_sb_entry.sv
// One scoreboard stage register: 1-cycle latency, freezes on hold, loads all-zero on bubble or reset.
module hazard_sb_entry #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         hold,
   input  logic         bubble,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);
   always_ff @(posedge clk) begin
      if (rst)
         q <= '0;
      else if (!hold)
         q <= bubble ? '0 : d;
   end
endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit: combinational stall/flush/forward controls from a DEPTH-stage scoreboard, Hold freezes it.
// HAZARD_FORWARDING_EN selects forwarding; without it the unit is a pure interlock.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int DEPTH      = DEPTH_DEF,
   parameter int REG_AW     = REG_AW_DEF,
   parameter int LOAD_STAGE = LOAD_STAGE_DEF,
   parameter int FWD_W      = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ValidD,
   input  logic [REG_AW-1:0] Rs1D,
   input  logic [REG_AW-1:0] Rs2D,
   input  logic              Rs1UseD,
   input  logic              Rs2UseD,
   input  logic [REG_AW-1:0] RdD,
   input  logic              RegWriteD,
   input  logic              IsLoadD,
   input  logic              PCSrcE,
   input  logic              Hold,
   output logic              StallF,
   output logic              StallD,
   output logic              FlushD,
   output logic              FlushE,
   output logic [FWD_W-1:0]  ForwardAE,
   output logic [FWD_W-1:0]  ForwardBE
);
   localparam int DW = dst_w(REG_AW);
   localparam int SW = src_w(REG_AW);

   logic [DEPTH-1:0][DW-1:0] dst;
   logic [DW-1:0]            dst_in;
   logic                     bubble0;
   logic                     hazard;

   function automatic logic producer_match(input logic [DW-1:0]     e,
                                           input logic [REG_AW-1:0] src,
                                           input logic              use_src);
      return use_src && e[E_VALID] && e[E_REGWRITE] &&
             (e[E_RD +: REG_AW] != '0) && (e[E_RD +: REG_AW] == src);
   endfunction

   assign dst_in  = {RdD, IsLoadD, RegWriteD, ValidD};
   assign bubble0 = FlushE | ~ValidD;

`ifdef HAZARD_FORWARDING_EN
   logic [SW-1:0]    src0;
   logic [DW+SW-1:0] e0_q;

   hazard_sb_entry #(.W(DW + SW)) u_entry0 (
      .clk    (clk),
      .rst    (rst),
      .hold   (Hold),
      .bubble (bubble0),
      .d      ({Rs2D, Rs1D, Rs2UseD, Rs1UseD, dst_in}),
      .q      (e0_q)
   );
   assign dst[0] = e0_q[DW-1:0];
   assign src0   = e0_q[DW +: SW];
`else
   hazard_sb_entry #(.W(DW)) u_entry0 (
      .clk    (clk),
      .rst    (rst),
      .hold   (Hold),
      .bubble (bubble0),
      .d      (dst_in),
      .q      (dst[0])
   );
`endif

   for (genvar k = 1; k < DEPTH; k++) begin : g_stage
      hazard_sb_entry #(.W(DW)) u_entry (
         .clk    (clk),
         .rst    (rst),
         .hold   (Hold),
         .bubble (1'b0),
         .d      (dst[k-1]),
         .q      (dst[k])
      );
   end

   // The last stage never hazards D: the register file writes before it is read.
   always_comb begin
      hazard = 1'b0;
      for (int s = 0; s < DEPTH; s++) begin
         if (ValidD && (producer_match(dst[s], Rs1D, Rs1UseD) ||
                        producer_match(dst[s], Rs2D, Rs2UseD))) begin
`ifdef HAZARD_FORWARDING_EN
            if (dst[s][E_IS_LOAD] && (s + 1 < LOAD_STAGE))
               hazard = 1'b1;
`else
            if ((s <= DEPTH - 2) || (dst[s][E_IS_LOAD] && (s + 1 < LOAD_STAGE)))
               hazard = 1'b1;
`endif
         end
      end
   end

   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      if (Hold) begin
         StallF = 1'b1;
         StallD = 1'b1;
      end else if (PCSrcE) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
      end else if (hazard) begin
         StallF = 1'b1;
         StallD = 1'b1;
         FlushE = 1'b1;
      end
   end

`ifdef HAZARD_FORWARDING_EN
   // Scan oldest to youngest so the youngest eligible producer overrides.
   always_comb begin
      ForwardAE = FWD_W'(FWD_RF);
      ForwardBE = FWD_W'(FWD_RF);
      for (int k = DEPTH - 1; k >= 1; k--) begin
         if (producer_match(dst[k], src0[S_RS1 +: REG_AW], src0[S_RS1_USE]) &&
             (!dst[k][E_IS_LOAD] || (k >= LOAD_STAGE)))
            ForwardAE = FWD_W'(k);
         if (producer_match(dst[k], src0[s_rs2(REG_AW) +: REG_AW], src0[S_RS2_USE]) &&
             (!dst[k][E_IS_LOAD] || (k >= LOAD_STAGE)))
            ForwardBE = FWD_W'(k);
      end
   end
`else
   assign ForwardAE = FWD_W'(FWD_RF);
   assign ForwardBE = FWD_W'(FWD_RF);
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (default parameters); expectations follow HAZARD_FORWARDING_EN.
module tb_hazard_scoreboard;
   logic       clk = 1'b0;
   logic       rst;
   logic       ValidD, Rs1UseD, Rs2UseD, RegWriteD, IsLoadD, PCSrcE, Hold;
   logic [4:0] Rs1D, Rs2D, RdD;
   logic       StallF, StallD, FlushD, FlushE;
   logic [1:0] ForwardAE, ForwardBE;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      string      tag;
      logic [3:0] ctl;
      logic [1:0] fa;
      logic [1:0] fb;
   } exp_t;
   exp_t expq[$];

   // {StallF, StallD, FlushD, FlushE}
   localparam logic [3:0] C_NONE  = 4'b0000;
   localparam logic [3:0] C_STALL = 4'b1101;
   localparam logic [3:0] C_FLUSH = 4'b0011;
   localparam logic [3:0] C_HOLD  = 4'b1100;
`ifdef HAZARD_FORWARDING_EN
   localparam logic [3:0] C_ILK = C_NONE;
   localparam logic [1:0] F_W2  = 2'd2;
`else
   localparam logic [3:0] C_ILK = C_STALL;
   localparam logic [1:0] F_W2  = 2'd0;
`endif

   always #5 clk = ~clk;

   hazard_scoreboard dut (
      .clk       (clk),
      .rst       (rst),
      .ValidD    (ValidD),
      .Rs1D      (Rs1D),
      .Rs2D      (Rs2D),
      .Rs1UseD   (Rs1UseD),
      .Rs2UseD   (Rs2UseD),
      .RdD       (RdD),
      .RegWriteD (RegWriteD),
      .IsLoadD   (IsLoadD),
      .PCSrcE    (PCSrcE),
      .Hold      (Hold),
      .StallF    (StallF),
      .StallD    (StallD),
      .FlushD    (FlushD),
      .FlushE    (FlushE),
      .ForwardAE (ForwardAE),
      .ForwardBE (ForwardBE)
   );

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, expv);
      end
   endtask

   // Called just after a rising edge; checks at the falling edge, returns just after the next rising edge.
   task automatic step(input string tag, input logic v, input logic [4:0] rd, input logic rw,
                       input logic ld, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                       input logic u2, input logic pc, input logic hd, input logic [3:0] ctl,
                       input logic [1:0] fa, input logic [1:0] fb);
      exp_t e;
      ValidD = v;  RdD = rd;  RegWriteD = rw;  IsLoadD = ld;
      Rs1D = r1;   Rs1UseD = u1;  Rs2D = r2;  Rs2UseD = u2;
      PCSrcE = pc; Hold = hd;
      e.tag = tag; e.ctl = ctl; e.fa = fa; e.fb = fb;
      expq.push_back(e);
      @(negedge clk);
      e = expq.pop_front();
      chk({e.tag, "/ctl"},  {StallF, StallD, FlushD, FlushE}, e.ctl);
      chk({e.tag, "/fwdA"}, {2'b00, ForwardAE}, {2'b00, e.fa});
      chk({e.tag, "/fwdB"}, {2'b00, ForwardBE}, {2'b00, e.fb});
      @(posedge clk);
      #1;
   endtask

   task automatic alu(input string tag, input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                      input logic [4:0] r2, input logic u2, input logic [3:0] ctl,
                      input logic [1:0] fa, input logic [1:0] fb);
      step(tag, 1'b1, rd, 1'b1, 1'b0, r1, u1, r2, u2, 1'b0, 1'b0, ctl, fa, fb);
   endtask

   task automatic lw(input string tag, input logic [4:0] rd, input logic [3:0] ctl,
                     input logic [1:0] fa, input logic [1:0] fb);
      step(tag, 1'b1, rd, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, ctl, fa, fb);
   endtask

   task automatic nop(input string tag, input logic [1:0] fa, input logic [1:0] fb);
      step(tag, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NONE, fa, fb);
   endtask

   task automatic rand_inputs();
      ValidD    = 1'($urandom_range(0, 1));
      Rs1D      = 5'($urandom_range(0, 31));
      Rs2D      = 5'($urandom_range(0, 31));
      Rs1UseD   = 1'($urandom_range(0, 1));
      Rs2UseD   = 1'($urandom_range(0, 1));
      RdD       = 5'($urandom_range(0, 31));
      RegWriteD = 1'($urandom_range(0, 1));
      IsLoadD   = 1'($urandom_range(0, 1));
      PCSrcE    = 1'($urandom_range(0, 1));
      Hold      = 1'($urandom_range(0, 1));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed no completion, required finish within 20000 cycles");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset held for two edges with random inputs.
      rst = 1'b1;
      rand_inputs();
      @(posedge clk);
      #1 rand_inputs();
      @(posedge clk);
      #1 rst = 1'b0;
      nop("rst_release", 2'd0, 2'd0);

      // x0 producer and unused sources never hazard or forward.
      alu("x0_prod", 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, C_NONE, 2'd0, 2'd0);
      alu("x0_cons", 5'd3, 5'd0, 1'b1, 5'd0, 1'b0, C_NONE, 2'd0, 2'd0);
      alu("use_off", 5'd4, 5'd3, 1'b0, 5'd3, 1'b0, C_NONE, 2'd0, 2'd0);
      nop("use_off_fwd", 2'd0, 2'd0);

      // Taken branch coincident with load-use: flush wins.
      lw("br_lw", 5'd6, C_NONE, 2'd0, 2'd0);
      step("br_flush", 1'b1, 5'd7, 1'b1, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1, 1'b1, 1'b0, C_FLUSH, 2'd0, 2'd0);
      nop("br_after", 2'd0, 2'd0);

      // Reset during a load-use stall clears the scoreboard.
      lw("rst_lw", 5'd6, C_NONE, 2'd0, 2'd0);
      rst = 1'b1;
      alu("rst_stall", 5'd7, 5'd0, 1'b0, 5'd6, 1'b1, C_STALL, 2'd0, 2'd0);
      rst = 1'b0;
      alu("rst_clear", 5'd7, 5'd0, 1'b0, 5'd6, 1'b1, C_NONE, 2'd0, 2'd0);
      nop("rst_clear_fwd", 2'd0, 2'd0);

      // Hold for three cycles masks the branch flush and freezes the scoreboard.
      alu("hold_prod", 5'd8, 5'd0, 1'b0, 5'd0, 1'b0, C_NONE, 2'd0, 2'd0);
      for (int i = 0; i < 3; i++)
         step("hold", 1'b1, 5'd10, 1'b1, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, C_HOLD, 2'd0, 2'd0);
      step("hold_release", 1'b1, 5'd10, 1'b1, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 1'b0, C_FLUSH, 2'd0, 2'd0);
      alu("hold_after", 5'd11, 5'd8, 1'b1, 5'd0, 1'b0, C_ILK, 2'd0, 2'd0);
      alu("hold_frozen", 5'd11, 5'd8, 1'b1, 5'd0, 1'b0, C_NONE, F_W2, 2'd0);
      for (int i = 0; i < 3; i++)
         nop("drain", 2'd0, 2'd0);

`ifdef HAZARD_FORWARDING_EN
      alu("alu_p", 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, C_NONE, 2'd0, 2'd0);
      alu("alu_c", 5'd9, 5'd5, 1'b1, 5'd0, 1'b0, C_NONE, 2'd0, 2'd0);
      nop("fwd_m", 2'd1, 2'd0);
      alu("gap_p", 5'd12, 5'd0, 1'b0, 5'd0, 1'b0, C_NONE, 2'd0, 2'd0);
      alu("gap_x", 5'd13, 5'd0, 1'b0, 5'd0, 1'b0, C_NONE, 2'd0, 2'd0);
      alu("gap_c", 5'd14, 5'd12, 1'b1, 5'd0, 1'b0, C_NONE, 2'd0, 2'd0);
      nop("fwd_w", 2'd2, 2'd0);
      alu("young_o", 5'd15, 5'd0, 1'b0, 5'd0, 1'b0, C_NONE, 2'd0, 2'd0);
      alu("young_y", 5'd15, 5'd0, 1'b0, 5'd0, 1'b0, C_NONE, 2'd0, 2'd0);
      alu("young_c", 5'd16, 5'd0, 1'b0, 5'd15, 1'b1, C_NONE, 2'd0, 2'd0);
      nop("fwd_young", 2'd0, 2'd1);
      lw("lu_p", 5'd6, C_NONE, 2'd0, 2'd0);
      alu("lu_c", 5'd17, 5'd0, 1'b0, 5'd6, 1'b1, C_STALL, 2'd0, 2'd0);
      alu("lu_c2", 5'd17, 5'd0, 1'b0, 5'd6, 1'b1, C_NONE, 2'd0, 2'd0);
      nop("lu_fwd", 2'd0, 2'd2);
`else
      alu("ilk_p", 5'd7, 5'd0, 1'b0, 5'd0, 1'b0, C_NONE, 2'd0, 2'd0);
      alu("ilk_c1", 5'd9, 5'd7, 1'b1, 5'd0, 1'b0, C_STALL, 2'd0, 2'd0);
      alu("ilk_c2", 5'd9, 5'd7, 1'b1, 5'd0, 1'b0, C_STALL, 2'd0, 2'd0);
      alu("ilk_c3", 5'd9, 5'd7, 1'b1, 5'd0, 1'b0, C_NONE, 2'd0, 2'd0);
      nop("ilk_d", 2'd0, 2'd0);
      lw("ilk_lu_p", 5'd6, C_NONE, 2'd0, 2'd0);
      alu("ilk_lu1", 5'd17, 5'd0, 1'b0, 5'd6, 1'b1, C_STALL, 2'd0, 2'd0);
      alu("ilk_lu2", 5'd17, 5'd0, 1'b0, 5'd6, 1'b1, C_STALL, 2'd0, 2'd0);
      alu("ilk_lu3", 5'd17, 5'd0, 1'b0, 5'd6, 1'b1, C_NONE, 2'd0, 2'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
